bp_me_mem_cmd_arbiter: RTL and testbench
========================================

# bp_me_mem_cmd_arbiter

Shares one BedRock memory port, such as the `bp_nonsynth_mem` command/response pair, between `num_req_p` requesters. Requesters include the CCE memory command path and the MMIO config loader path. Commands are granted round-robin and forwarded to memory. The requester ID of each accepted command goes into an in-order tag FIFO, and each memory response is steered back to the requester at the FIFO head. The block sits between the CCE-side command/response buffers and the memory model in the ME testbenches and in multi-CCE test configurations.

## Interface
- `num_req_p`, 2 — number of requesters; must be ≥2.
- `msg_width_p`, 64 — width of a packed `bp_bedrock_cce_mem_msg_s`, covering header and data.
- `outstanding_els_p`, 4 — maximum accepted commands awaiting response; power of two, ≥2.
- `clk_i`  in  1  — clock.
- `reset_n_i`  in  1  — synchronous, active-low reset.
- `req_cmd_i`  in  `num_req_p`×`msg_width_p`  — per-requester memory command.
- `req_cmd_v_i`  in  `num_req_p`  — command valid.
- `req_cmd_ready_and_o`  out  `num_req_p`  — command accepted this cycle when high with valid.
- `req_resp_o`  out  `msg_width_p`  — memory response, broadcast to all requesters.
- `req_resp_v_o`  out  `num_req_p`  — one-hot response valid.
- `req_resp_yumi_i`  in  `num_req_p`  — response consumed.
- `mem_cmd_o`  out  `msg_width_p`  — command to memory.
- `mem_cmd_v_o`  out  1  — command valid.
- `mem_cmd_ready_and_i`  in  1  — memory accepts command.
- `mem_resp_i`  in  `msg_width_p`  — memory response.
- `mem_resp_v_i`  in  1  — response valid.
- `mem_resp_yumi_o`  out  1  — response consumed.
- `error_o`  out  1  — sticky protocol error.
- `grant_cnt_o`  out  `num_req_p`×32  — per-requester accepted-command count; see Configuration.

## Operation
- **Arbitration.** Round-robin over `req_cmd_v_i`.
  - Priority starts at requester `rr_ptr`. `rr_ptr` advances to the winner+1 (mod `num_req_p`) only on a command handshake (`mem_cmd_v_o & mem_cmd_ready_and_i`).
- **Grant lock.** When `mem_cmd_v_o` is high and `mem_cmd_ready_and_i` is low, the grant is registered and held until the handshake.
  - A later-arriving higher-priority requester does not preempt.
  - `mem_cmd_o` stays stable while valid.
  - A requester that drops valid while locked violates protocol: set `error_o`, release the lock.
- **Command path.**
  - `mem_cmd_o` = `req_cmd_i[grant]`.
  - `mem_cmd_v_o` = `|req_cmd_v_i & ~tag_full`.
  - `req_cmd_ready_and_o[grant]` = `mem_cmd_ready_and_i & ~tag_full`; all other bits are 0.
- **Tag FIFO.** Holds `clog2(num_req_p)`-bit IDs.
  - Push on command handshake; pop on response handshake.
  - Full blocks a push even if a pop occurs the same cycle.
  - A simultaneous push and pop when not full leaves the count unchanged.
- **Response path.**
  - `req_resp_o` = `mem_resp_i`.
  - `req_resp_v_o` = one-hot(head) & {`mem_resp_v_i` & ~`tag_empty`}.
  - `mem_resp_yumi_o` = `mem_resp_v_i & req_resp_yumi_i[head] & ~tag_empty`.
- **Stray response.** `mem_resp_v_i` high while the tag FIFO is empty sets `error_o`. The response is not consumed.
- **Error.** `error_o` clears only on reset.

## Timing
- **Reset** (while `reset_n_i`=0, sampled at posedge):
  - `rr_ptr`=0, lock clear, tag FIFO empty, `error_o`=0, counters=0.
  - All ready, valid and yumi outputs are forced 0.
- **Latency.**
  - Command: 0 cycles, combinational, from requester valid to `mem_cmd_v_o`.
  - Response: 0 cycles from `mem_resp_v_i` to `req_resp_v_o`.
  - No combinational path from `mem_cmd_ready_and_i` to grant selection; grant depends only on valids, `rr_ptr` and lock.
- **State updates.** Tag push/pop, `rr_ptr`, lock and counters update at posedge.
- **Throughput.**
  - 1 command/cycle when memory is ready and the FIFO is not full.
  - 1 response/cycle.
- **Reset mid-operation.** Outstanding tags are discarded. Responses arriving after reset are flagged as stray.

## Configuration
- **`BP_ME_MEM_ARB_STATS_EN` defined.**
  - `grant_cnt_o[i]` increments on each command handshake from requester i.
  - The count saturates at 2^32−1.
- **Macro undefined.** `grant_cnt_o` is tied to 0 and no counter flops are instantiated.

## Structure
- **Shared package (`bp_me_pkg`).**
  - Localparam function for tag width: `clog2(num_req_p)`, minimum 1.
  - `bp_me_arb_err_e` enum, for debug only: `e_arb_ok`, `e_arb_stray_resp`, `e_arb_drop_valid`.
- **Sub-module.** `bp_me_mem_arb_tag_fifo`, a circular buffer of depth `outstanding_els_p`.
  - Read/write pointers one bit wider than the index, so full/empty is decoded from the MSB.
  - Wrap-around is by natural overflow.
- **Arbiter.** Round-robin arbitration is inline logic.

## Test plan
- **Contention.**
  - Stimulus: both requesters hold valid, memory always ready, 4 cycles.
  - Required: grants alternate 0,1,0,1; responses return to 0,1,0,1; `grant_cnt_o`={2,2} with the macro defined.
- **Lock.**
  - Stimulus: requester 1 is granted with `mem_cmd_ready_and_i`=0 for 3 cycles, while requester 0 raises valid at cycle 1.
  - Required: `mem_cmd_o` stays requester 1's message; requester 0 is granted on the cycle after the handshake.
- **Full.**
  - Stimulus: 4 commands accepted, no responses.
  - Required: 5th command sees `mem_cmd_v_o`=0 and ready=0. The cycle after one response pops, ready returns.
- **Ordering.**
  - Stimulus: issue IDs 1,0,1; memory returns 3 responses; `req_resp_yumi_i[0]` is held low.
  - Required: first response delivered to 1; second stalls with `mem_resp_yumi_o`=0 until requester 0's yumi.
- **Stray response / reset.**
  - Stimulus: `mem_resp_v_i`=1 with an empty FIFO.
  - Required: `error_o`=1 next cycle and `mem_resp_yumi_o`=0; asserting `reset_n_i`=0 clears `error_o` and empties the FIFO.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared types and helpers for the ME memory command arbiter.
package bp_me_pkg;

    // Debug-only classification of the sticky protocol error.
    typedef enum logic [1:0] {
        e_arb_ok,
        e_arb_stray_resp,
        e_arb_drop_valid
    } bp_me_arb_err_e;

    // Requester tag width; a 1-bit tag is kept even for degenerate counts.
    function automatic int bp_me_tag_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/bp_me_mem_arb_tag_fifo.sv
// In-order requester-ID FIFO; pointers carry an extra wrap bit for full/empty.
module bp_me_mem_arb_tag_fifo
    import bp_me_pkg::*;
#(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               push_i,
    input  logic               pop_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int idx_w_lp = $clog2(els_p);

    logic [idx_w_lp:0]                wptr_r, rptr_r;
    logic [els_p-1:0][width_p-1:0]    mem_r;
    logic                             push_en, pop_en;

    assign empty_o = (wptr_r == rptr_r);
    assign full_o  = (wptr_r[idx_w_lp] != rptr_r[idx_w_lp])
                  && (wptr_r[idx_w_lp-1:0] == rptr_r[idx_w_lp-1:0]);

    // A full FIFO refuses a push even when a pop frees a slot this cycle.
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;
    assign data_o  = mem_r[rptr_r[idx_w_lp-1:0]];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (push_en) wptr_r <= wptr_r + {{idx_w_lp{1'b0}}, 1'b1};
            if (pop_en)  rptr_r <= rptr_r + {{idx_w_lp{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) mem_r[wptr_r[idx_w_lp-1:0]] <= data_i;
    end

endmodule

// File: rtl/bp_me_mem_cmd_arbiter.sv
// Round-robin share of one BedRock memory port; responses steered by an in-order tag FIFO.
// Optional per-requester grant counters under BP_ME_MEM_ARB_STATS_EN.
module bp_me_mem_cmd_arbiter
    import bp_me_pkg::*;
#(
    parameter int num_req_p         = 2,
    parameter int msg_width_p       = 64,
    parameter int outstanding_els_p = 4
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [num_req_p-1:0][msg_width_p-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]                  req_cmd_v_i,
    output logic [num_req_p-1:0]                  req_cmd_ready_and_o,
    output logic [msg_width_p-1:0]                req_resp_o,
    output logic [num_req_p-1:0]                  req_resp_v_o,
    input  logic [num_req_p-1:0]                  req_resp_yumi_i,
    output logic [msg_width_p-1:0]                mem_cmd_o,
    output logic                                  mem_cmd_v_o,
    input  logic                                  mem_cmd_ready_and_i,
    input  logic [msg_width_p-1:0]                mem_resp_i,
    input  logic                                  mem_resp_v_i,
    output logic                                  mem_resp_yumi_o,
    output logic                                  error_o,
    output logic [num_req_p-1:0][31:0]            grant_cnt_o
);

    localparam int                  tag_w_lp   = bp_me_tag_width(num_req_p);
    localparam logic [tag_w_lp-1:0] last_id_lp = tag_w_lp'(num_req_p - 1);

    logic [tag_w_lp-1:0] rr_ptr_r, lock_id_r, rr_grant, grant, head;
    logic                lock_r, lock_live, drop_valid, found;
    logic                tag_full, tag_empty, cmd_hs, resp_live, stray_resp, error_r;
    int                  idx;
    bp_me_arb_err_e      err_cause;

    // Rotating priority starting at rr_ptr; never looks at memory ready.
    always_comb begin
        rr_grant = rr_ptr_r;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = (int'(rr_ptr_r) + i) % num_req_p;
            if (!found && req_cmd_v_i[idx]) begin
                found    = 1'b1;
                rr_grant = tag_w_lp'(idx);
            end
        end
    end

    // A locked requester that withdraws loses the lock and falls back to round-robin.
    assign lock_live  = lock_r & req_cmd_v_i[lock_id_r];
    assign drop_valid = lock_r & ~req_cmd_v_i[lock_id_r];
    assign grant      = lock_live ? lock_id_r : rr_grant;

    assign mem_cmd_o   = req_cmd_i[grant];
    assign mem_cmd_v_o = reset_n_i & (|req_cmd_v_i) & ~tag_full;
    assign cmd_hs      = mem_cmd_v_o & mem_cmd_ready_and_i;

    always_comb begin
        req_cmd_ready_and_o        = '0;
        req_cmd_ready_and_o[grant] = reset_n_i & mem_cmd_ready_and_i & ~tag_full;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rr_ptr_r  <= '0;
            lock_r    <= 1'b0;
            lock_id_r <= '0;
        end else if (cmd_hs) begin
            rr_ptr_r <= (grant == last_id_lp) ? '0 : grant + tag_w_lp'(1);
            lock_r   <= 1'b0;
        end else if (mem_cmd_v_o) begin
            lock_r    <= 1'b1;
            lock_id_r <= grant;
        end else begin
            lock_r <= 1'b0;
        end
    end

    bp_me_mem_arb_tag_fifo #(
        .width_p (tag_w_lp),
        .els_p   (outstanding_els_p)
    ) tag_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (grant),
        .push_i    (cmd_hs),
        .pop_i     (mem_resp_yumi_o),
        .data_o    (head),
        .full_o    (tag_full),
        .empty_o   (tag_empty)
    );

    assign req_resp_o      = mem_resp_i;
    assign resp_live       = reset_n_i & mem_resp_v_i & ~tag_empty;
    assign mem_resp_yumi_o = resp_live & req_resp_yumi_i[head];
    assign stray_resp      = mem_resp_v_i & tag_empty;

    always_comb begin
        req_resp_v_o       = '0;
        req_resp_v_o[head] = resp_live;
    end

    always_comb begin
        err_cause = e_arb_ok;
        if (stray_resp)      err_cause = e_arb_stray_resp;
        else if (drop_valid) err_cause = e_arb_drop_valid;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) error_r <= 1'b0;
        else            error_r <= error_r | (err_cause != e_arb_ok);
    end
    assign error_o = error_r;

`ifdef BP_ME_MEM_ARB_STATS_EN
    logic [num_req_p-1:0][31:0] cnt_r;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_r <= '0;
        end else begin
            for (int i = 0; i < num_req_p; i++) begin
                if (cmd_hs && (grant == tag_w_lp'(i)) && (cnt_r[i] != '1))
                    cnt_r[i] <= cnt_r[i] + 32'd1;
            end
        end
    end
    assign grant_cnt_o = cnt_r;
`else
    assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Scoreboard bench: expected response destinations queued at command drive, checked on delivery.
module tb_bp_me_mem_cmd_arbiter;

    localparam int N = 2;
    localparam int W = 64;

    logic                  clk = 1'b0;
    logic                  reset_n_i;
    logic [N-1:0][W-1:0]   req_cmd_i;
    logic [N-1:0]          req_cmd_v_i;
    logic [N-1:0]          req_cmd_ready_and_o;
    logic [W-1:0]          req_resp_o;
    logic [N-1:0]          req_resp_v_o;
    logic [N-1:0]          req_resp_yumi_i;
    logic [W-1:0]          mem_cmd_o;
    logic                  mem_cmd_v_o;
    logic                  mem_cmd_ready_and_i;
    logic [W-1:0]          mem_resp_i;
    logic                  mem_resp_v_i;
    logic                  mem_resp_yumi_o;
    logic                  error_o;
    logic [N-1:0][31:0]    grant_cnt_o;

    typedef struct {
        int           id;
        logic [W-1:0] msg;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] mem_q[$];
    int           n_chk = 0;
    int           n_err = 0;

    bp_me_mem_cmd_arbiter #(
        .num_req_p         (N),
        .msg_width_p       (W),
        .outstanding_els_p (4)
    ) dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n_i),
        .req_cmd_i           (req_cmd_i),
        .req_cmd_v_i         (req_cmd_v_i),
        .req_cmd_ready_and_o (req_cmd_ready_and_o),
        .req_resp_o          (req_resp_o),
        .req_resp_v_o        (req_resp_v_o),
        .req_resp_yumi_i     (req_resp_yumi_i),
        .mem_cmd_o           (mem_cmd_o),
        .mem_cmd_v_o         (mem_cmd_v_o),
        .mem_cmd_ready_and_i (mem_cmd_ready_and_i),
        .mem_resp_i          (mem_resp_i),
        .mem_resp_v_i        (mem_resp_v_i),
        .mem_resp_yumi_o     (mem_resp_yumi_o),
        .error_o             (error_o),
        .grant_cnt_o         (grant_cnt_o)
    );

    always #5 clk = ~clk;

    // Memory model: echoes each accepted command back as its response, in order.
    always @(posedge clk) begin
        if (!reset_n_i) begin
            mem_q.delete();
        end else begin
            if (mem_cmd_v_o && mem_cmd_ready_and_i) mem_q.push_back(mem_cmd_o);
            if (mem_resp_yumi_o) void'(mem_q.pop_front());
        end
    end

    function automatic logic [W-1:0] mk(input int id, input int seq);
        return (64'(id) << 56) | 64'(seq) | 64'h00C0_0000_0000_0000;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic rdy, input logic rv,
                         input logic [N-1:0] yumi, input logic [W-1:0] m0, input logic [W-1:0] m1);
        @(negedge clk);
        req_cmd_v_i         = v;
        req_cmd_i[0]        = m0;
        req_cmd_i[1]        = m1;
        mem_cmd_ready_and_i = rdy;
        mem_resp_v_i        = rv;
        req_resp_yumi_i     = yumi;
        mem_resp_i          = (mem_q.size() > 0) ? mem_q[0] : 64'hDEAD_BEEF_0000_0000;
        #1;
    endtask

    task automatic idle();
        drive('0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic chk_cmd(input string tag, input int g, input logic [W-1:0] msg, input logic hs);
        chk({tag, "_v"}, 64'(mem_cmd_v_o), 64'd1);
        chk({tag, "_d"}, mem_cmd_o, msg);
        chk({tag, "_rdy"}, 64'(req_cmd_ready_and_o), hs ? (64'd1 << g) : 64'd0);
        if (hs) sb.push_back('{g, msg});
    endtask

    task automatic chk_resp(input string tag, input logic consume);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb[0];
            chk({tag, "_v"}, 64'(req_resp_v_o), 64'd1 << e.id);
            chk({tag, "_d"}, req_resp_o, e.msg);
            chk({tag, "_yumi"}, 64'(mem_resp_yumi_o), 64'(consume));
            if (consume) void'(sb.pop_front());
        end
    endtask

    initial begin
        logic [W-1:0] exp_cnt;
        reset_n_i           = 1'b0;
        req_cmd_v_i         = '0;
        req_cmd_i           = '0;
        mem_cmd_ready_and_i = 1'b0;
        mem_resp_v_i        = 1'b0;
        mem_resp_i          = '0;
        req_resp_yumi_i     = '0;

        // Reset: outputs forced quiet even with everything asserted
        drive(2'b11, 1'b1, 1'b1, 2'b11, mk(0, 1), mk(1, 1));
        drive(2'b11, 1'b1, 1'b1, 2'b11, mk(0, 1), mk(1, 1));
        chk("rst_cmd_v", 64'(mem_cmd_v_o), 64'd0);
        chk("rst_rdy", 64'(req_cmd_ready_and_o), 64'd0);
        chk("rst_resp_v", 64'(req_resp_v_o), 64'd0);
        chk("rst_yumi", 64'(mem_resp_yumi_o), 64'd0);
        chk("rst_err", 64'(error_o), 64'd0);
        chk("rst_cnt", 64'(grant_cnt_o), 64'd0);
        idle();
        reset_n_i = 1'b1;

        // Contention: grants alternate 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 1'b1, 1'b0, 2'b00, mk(0, k), mk(1, k));
            chk_cmd("cont", k % 2, (k % 2 == 0) ? mk(0, k) : mk(1, k), 1'b1);
        end
        idle();
`ifdef BP_ME_MEM_ARB_STATS_EN
        exp_cnt = {32'd2, 32'd2};
`else
        exp_cnt = 64'd0;
`endif
        chk("cont_cnt", 64'(grant_cnt_o), exp_cnt);
        for (int k = 0; k < 4; k++) begin
            drive(2'b00, 1'b0, 1'b1, 2'b11, '0, '0);
            chk_resp("cont_r", 1'b1);
        end

        // Lock: requester 1 held without preemption while memory stalls
        drive(2'b10, 1'b0, 1'b0, 2'b00, mk(0, 10), mk(1, 10));
        chk_cmd("lock_c0", 1, mk(1, 10), 1'b0);
        for (int k = 0; k < 2; k++) begin
            drive(2'b11, 1'b0, 1'b0, 2'b00, mk(0, 10), mk(1, 10));
            chk_cmd("lock_hold", 1, mk(1, 10), 1'b0);
        end
        drive(2'b11, 1'b1, 1'b0, 2'b00, mk(0, 10), mk(1, 10));
        chk_cmd("lock_hs", 1, mk(1, 10), 1'b1);
        drive(2'b11, 1'b1, 1'b0, 2'b00, mk(0, 10), mk(1, 10));
        chk_cmd("lock_next", 0, mk(0, 10), 1'b1);
        for (int k = 0; k < 2; k++) begin
            drive(2'b00, 1'b0, 1'b1, 2'b11, '0, '0);
            chk_resp("lock_r", 1'b1);
        end

        // Full: four outstanding block the fifth, even across a pop
        for (int k = 0; k < 4; k++) begin
            drive(2'b01, 1'b1, 1'b0, 2'b00, mk(0, 20 + k), '0);
            chk_cmd("full_fill", 0, mk(0, 20 + k), 1'b1);
        end
        drive(2'b01, 1'b1, 1'b0, 2'b00, mk(0, 24), '0);
        chk("full_v", 64'(mem_cmd_v_o), 64'd0);
        chk("full_rdy", 64'(req_cmd_ready_and_o), 64'd0);
        drive(2'b01, 1'b1, 1'b1, 2'b11, mk(0, 24), '0);
        chk("full_pop_v", 64'(mem_cmd_v_o), 64'd0);
        chk("full_pop_rdy", 64'(req_cmd_ready_and_o), 64'd0);
        chk_resp("full_pop_r", 1'b1);
        drive(2'b01, 1'b1, 1'b0, 2'b00, mk(0, 24), '0);
        chk_cmd("full_after", 0, mk(0, 24), 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive(2'b00, 1'b0, 1'b1, 2'b11, '0, '0);
            chk_resp("full_r", 1'b1);
        end

        // Ordering: IDs 1,0,1; requester 0 stalls the second response
        drive(2'b10, 1'b1, 1'b0, 2'b00, '0, mk(1, 30));
        chk_cmd("ord_c0", 1, mk(1, 30), 1'b1);
        drive(2'b01, 1'b1, 1'b0, 2'b00, mk(0, 31), '0);
        chk_cmd("ord_c1", 0, mk(0, 31), 1'b1);
        drive(2'b10, 1'b1, 1'b0, 2'b00, '0, mk(1, 32));
        chk_cmd("ord_c2", 1, mk(1, 32), 1'b1);
        drive(2'b00, 1'b0, 1'b1, 2'b10, '0, '0);
        chk_resp("ord_r0", 1'b1);
        for (int k = 0; k < 2; k++) begin
            drive(2'b00, 1'b0, 1'b1, 2'b10, '0, '0);
            chk_resp("ord_stall", 1'b0);
        end
        drive(2'b00, 1'b0, 1'b1, 2'b01, '0, '0);
        chk_resp("ord_r1", 1'b1);
        drive(2'b00, 1'b0, 1'b1, 2'b10, '0, '0);
        chk_resp("ord_r2", 1'b1);
        chk("ord_err", 64'(error_o), 64'd0);

        // Stray response with an empty FIFO
        drive(2'b00, 1'b0, 1'b1, 2'b11, '0, '0);
        chk("stray_yumi", 64'(mem_resp_yumi_o), 64'd0);
        chk("stray_resp_v", 64'(req_resp_v_o), 64'd0);
        idle();
        chk("stray_err", 64'(error_o), 64'd1);
        drive(2'b01, 1'b1, 1'b0, 2'b00, mk(0, 40), '0);
        chk_cmd("stray_cmd", 0, mk(0, 40), 1'b1);
        chk("stray_sticky", 64'(error_o), 64'd1);

        // Reset mid-operation discards the outstanding tag and clears the error
        idle();
        reset_n_i = 1'b0;
        idle();
        chk("rst2_err", 64'(error_o), 64'd0);
        reset_n_i = 1'b1;
        sb.delete();
        drive(2'b00, 1'b0, 1'b1, 2'b11, '0, '0);
        chk("rst2_resp_v", 64'(req_resp_v_o), 64'd0);
        chk("rst2_yumi", 64'(mem_resp_yumi_o), 64'd0);
        idle();
        chk("rst2_stray", 64'(error_o), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
